// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field positions, constants and flag indices
// used by the fadd result stage and its special-case fix-up logic.
package fp_pkg;

    localparam int SIGN      = 31;
    localparam int EXP_MSB   = 30;
    localparam int EXP_LSB   = 23;
    localparam int MAN_MSB   = 22;
    localparam int MAN_LSB   = 0;
    localparam int QUIET_BIT = 22;

    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [31:0] CANON_NAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF      = 32'h7F800000;

    localparam int NV       = 4;
    localparam int DZ       = 3;
    localparam int OF       = 2;
    localparam int UF       = 1;
    localparam int NX       = 0;
    localparam int FFLAGS_W = 5;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (x[MAN_MSB:MAN_LSB] != '0);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[QUIET_BIT];
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (x[MAN_MSB:MAN_LSB] == '0);
    endfunction

endpackage

// File: rtl/fp_special_fixup.sv
// Combinational repair of NaN / infinity / overflow cases the adder datapath
// ignores, producing the final result and RISC-V fflags.
module fp_special_fixup
    import fp_pkg::*;
(
    input  logic [31:0]          frs1,
    input  logic [31:0]          frs2,
    input  logic                 Funct,
    input  logic [31:0]          frd_raw,
    output logic [31:0]          frd,
    output logic [FFLAGS_W-1:0]  fflags
);

    logic sb;
    assign sb = frs2[SIGN] ^ Funct;

    // Effective sign of operand 2 decides whether Inf +/- Inf is invalid.
    always_comb begin
        frd    = frd_raw;
        fflags = '0;
        if (is_nan(frs1) || is_nan(frs2)) begin
            frd        = CANON_NAN;
            fflags[NV] = is_snan(frs1) || is_snan(frs2);
        end else if (is_inf(frs1) && is_inf(frs2) && (frs1[SIGN] != sb)) begin
            frd        = CANON_NAN;
            fflags[NV] = 1'b1;
        end else if (is_inf(frs1)) begin
            frd = frs1;
        end else if (is_inf(frs2)) begin
            frd = {sb, POS_INF[EXP_MSB:0]};
        end else if (frd_raw[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) begin
            frd        = {frd_raw[SIGN], EXP_ALL_ONES, {(MAN_MSB+1){1'b0}}};
            fflags[OF] = 1'b1;
            fflags[NX] = 1'b1;
        end
    end

endmodule

// File: rtl/fadd_result_stage.sv
// Registered output stage for fadd/fsub: fixes special cases on entry and
// buffers results in a small valid/ready FIFO toward FP writeback.
module fadd_result_stage
    import fp_pkg::*;
#(
    parameter int FLEN  = 32,
    parameter int RD_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLEN-1:0]      frs1,
    input  logic [FLEN-1:0]      frs2,
    input  logic                 Funct,
    input  logic [FLEN-1:0]      frd_raw,
    input  logic [RD_W-1:0]      rd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLEN-1:0]      frd,
    output logic [RD_W-1:0]      rd_out,
    output logic [FFLAGS_W-1:0]  fflags
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLEN-1:0]     fix_frd;
    logic [FFLAGS_W-1:0] fix_flags;

    fp_special_fixup u_fixup (
        .frs1    (frs1),
        .frs2    (frs2),
        .Funct   (Funct),
        .frd_raw (frd_raw),
        .frd     (fix_frd),
        .fflags  (fix_flags)
    );

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [FLEN-1:0]     frd_mem_q   [DEPTH];
    logic [FLEN-1:0]     frd_mem_d   [DEPTH];
    logic [RD_W-1:0]     rd_mem_q    [DEPTH];
    logic [RD_W-1:0]     rd_mem_d    [DEPTH];
    logic [FFLAGS_W-1:0] flags_mem_q [DEPTH];
    logic [FFLAGS_W-1:0] flags_mem_d [DEPTH];

    logic push, pop;

    // in_ready looks only at the registered count: a full buffer refuses
    // even when it is draining in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        frd_mem_d   = frd_mem_q;
        rd_mem_d    = rd_mem_q;
        flags_mem_d = flags_mem_q;
        if (push) begin
            frd_mem_d[wr_ptr_q]   = fix_frd;
            rd_mem_d[wr_ptr_q]    = rd_in;
            flags_mem_d[wr_ptr_q] = fix_flags;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                frd_mem_q[gi]   <= '0;
                rd_mem_q[gi]    <= '0;
                flags_mem_q[gi] <= '0;
            end else begin
                frd_mem_q[gi]   <= frd_mem_d[gi];
                rd_mem_q[gi]    <= rd_mem_d[gi];
                flags_mem_q[gi] <= flags_mem_d[gi];
            end
        end
    end

    // Outputs read as zero whenever the buffer is empty.
    assign frd    = out_valid ? frd_mem_q[rd_ptr_q]   : '0;
    assign rd_out = out_valid ? rd_mem_q[rd_ptr_q]    : '0;
    assign fflags = out_valid ? flags_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fadd_result_stage.sv
// Randomized bench for fadd_result_stage: a queue-based reference model is
// compared on every falling edge, plus directed literal checks.
module tb_fadd_result_stage;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] frs1, frs2, frd_raw, frd;
    logic        Funct;
    logic [4:0]  rd_in, rd_out, fflags;
    logic        out_valid, out_ready;

    fadd_result_stage #(.FLEN(32), .RD_W(5), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frs1      (frs1),
        .frs2      (frs2),
        .Funct     (Funct),
        .frd_raw   (frd_raw),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frd       (frd),
        .rd_out    (rd_out),
        .fflags    (fflags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] frd;
        logic [4:0]  rd;
        logic [4:0]  fl;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  popped[$];
    int          n_total = 0;
    int          n_pass  = 0;
    bit          chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: classify operands and apply the special-case rules in order.
    function automatic ent_t ref_fix(input logic [31:0] a, input logic [31:0] b,
                                     input logic f, input logic [31:0] raw,
                                     input logic [4:0] rd);
        ent_t e;
        logic sb;
        logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
        sb     = b[31] ^ f;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        e.rd   = rd;
        e.fl   = 5'b00000;
        e.frd  = raw;
        if (a_nan || b_nan) begin
            e.frd = 32'h7FC00000;
            if (a_snan || b_snan) e.fl = 5'b10000;
        end else if (a_inf && b_inf && (a[31] != sb)) begin
            e.frd = 32'h7FC00000;
            e.fl  = 5'b10000;
        end else if (a_inf) begin
            e.frd = a;
        end else if (b_inf) begin
            e.frd = sb ? 32'hFF800000 : 32'h7F800000;
        end else if (raw[30:23] == 8'hFF) begin
            e.frd = raw[31] ? 32'hFF800000 : 32'h7F800000;
            e.fl  = 5'b00101;
        end
        return e;
    endfunction

    always @(negedge CLK) begin : compare
        ent_t h;
        if (chk_en) begin
            if (mq.size() != 0) h = mq[0];
            else begin
                h.frd = 32'd0; h.rd = 5'd0; h.fl = 5'd0;
            end
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
            chk("frd",       frd,            h.frd);
            chk("rd_out",    32'(rd_out),    32'(h.rd));
            chk("fflags",    32'(fflags),    32'(h.fl));
        end
    end

    task automatic step(input bit v, input bit rdy, input logic [31:0] a, input logic [31:0] b,
                        input bit f, input logic [31:0] raw, input logic [4:0] rd, output bit acc);
        bit do_pop;
        in_valid  = v;
        out_ready = rdy;
        frs1 = a; frs2 = b; Funct = f; frd_raw = raw; rd_in = rd;
        acc    = v && (mq.size() < DEPTH);
        do_pop = (mq.size() != 0) && rdy;
        if (do_pop) popped.push_back(rd_out);
        @(posedge CLK);
        if (do_pop) void'(mq.pop_front());
        if (acc) mq.push_back(ref_fix(a, b, f, raw, rd));
        @(negedge CLK);
    endtask

    task automatic idle(input bit rdy);
        bit acc;
        step(1'b0, rdy, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 20) begin idle(1'b1); n++; end
        chk("drain_bound", 32'(mq.size()), 32'd0);
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input bit f, input logic [31:0] raw, input logic [4:0] rd,
                            input logic [31:0] exp_frd, input logic [4:0] exp_fl);
        bit acc;
        step(1'b1, 1'b1, a, b, f, raw, rd, acc);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_frd"}, frd, exp_frd);
        chk({name, "_rd"}, 32'(rd_out), 32'(rd));
        chk({name, "_fl"}, 32'(fflags), 32'(exp_fl));
        $display("op %s: frd=%h rd=%0d fflags=%b", name, frd, rd_out, fflags);
        drain();
    endtask

    function automatic logic [31:0] rand_op();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 7))
            0:       return {s, 8'hFF, 23'd0};
            1:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            2:       return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
            3:       return {s, 31'h7F7FFFFF};
            default: return {s, 8'($urandom_range(0, 254)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        ent_t e;
        bit   acc;
        int   n;
        RST = 1'b1; in_valid = 0; out_ready = 0;
        frs1 = 0; frs2 = 0; Funct = 0; frd_raw = 0; rd_in = 0;

        // Pin the reference model against hand-computed values.
        e = ref_fix(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd7);
        chk("pin_add", e.frd, 32'h40400000);
        e = ref_fix(32'h7F800000, 32'h7F800000, 1'b1, 32'h0, 5'd0);
        chk("pin_infinf", {e.frd[26:0], e.fl}, {27'h7C00000 >> 0, 5'b10000} & 32'hFFFFFFFF);
        e = ref_fix(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F812345, 5'd0);
        chk("pin_ovf_fl", 32'(e.fl), 32'b00101);
        e = ref_fix(32'h3F800000, 32'h7F800000, 1'b1, 32'h0, 5'd0);
        chk("pin_ninf", e.frd, 32'hFF800000);

        repeat (2) @(negedge CLK);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_frd",       frd,            32'd0);
        chk("rst_fflags",    32'(fflags),    32'd0);
        RST = 1'b0;
        chk_en = 1;

        directed("add",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd7, 32'h40400000, 5'b00000);
        directed("inf_sub", 32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 5'd4, 32'h7FC00000, 5'b10000);
        directed("inf_add", 32'h7F800000, 32'h7F800000, 1'b0, 32'h00000000, 5'd5, 32'h7F800000, 5'b00000);
        directed("snan",    32'h7F800001, 32'h3F800000, 1'b0, 32'h3F800000, 5'd6, 32'h7FC00000, 5'b10000);
        directed("qnan",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h3F800000, 5'd8, 32'h7FC00000, 5'b00000);
        directed("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F812345, 5'd9, 32'h7F800000, 5'b00101);

        // Backpressure: two accepts, third held upstream, in-order drain.
        popped.delete();
        step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'd1, acc);
        step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'd2, acc);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'd3, acc);
        chk("bp_third_refused", 32'(acc), 32'd0);
        chk("bp_head_stable", 32'(rd_out), 32'd1);
        acc = 0; n = 0;
        while (!acc && n < 10) begin
            step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'd3, acc);
            n++;
        end
        chk("bp_third_accepted", 32'(acc), 32'd1);
        drain();
        chk("bp_pop_count", 32'(popped.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("bp_order", 32'((popped.size() > i) ? popped[i] : 5'd0), 32'(i + 1));
        $display("backpressure: popped %0d entries", popped.size());

        // Reset with two entries buffered.
        step(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd10, acc);
        step(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd11, acc);
        in_valid = 0;
        #2 RST = 1'b1;
        mq.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_fflags",    32'(fflags),    32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd12, acc);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_rd",    32'(rd_out),    32'd12);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b, raw;
            a = rand_op();
            b = rand_op();
            raw = ($urandom_range(0, 3) == 0) ? {1'($urandom), 8'hFF, 23'($urandom)}
                                              : {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), a, b,
                 1'($urandom), raw, 5'($urandom), acc);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fadd_result_stage.md
Name: fadd_result_stage

Overview:
- Registered output stage directly downstream of the combinational fadd_fsub datapath.
- Captures the raw sum/difference together with both source operands, Funct and the destination register index.
- Fixes up IEEE-754 single-precision special cases that the datapath does not handle: NaN, infinity and exponent overflow.
- Generates RISC-V fflags and delivers the result to FP writeback through a 2-entry valid/ready buffer, so writeback stalls never drop an issued operation.

Parameters:
- FLEN, 32, operand/result width (single precision only).
- RD_W, 5, destination register index width.
- DEPTH, 2, buffer entries (power of two, >= 2).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents an operation this cycle.
- in_ready  output  1  stage can accept (buffer not full).
- frs1  input  FLEN  operand 1 as given to the adder.
- frs2  input  FLEN  operand 2 as given to the adder.
- Funct  input  1  0 = add, 1 = sub.
- frd_raw  input  FLEN  combinational result from fadd_fsub.
- rd_in  input  RD_W  destination register index.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head entry.
- frd  output  FLEN  final result.
- rd_out  output  RD_W  destination index of head entry.
- fflags  output  5  {NV,DZ,OF,UF,NX}.

Behaviour:
- Reset (async assert, sync release):
  - Read pointer, write pointer and count = 0.
  - out_valid = 0; in_ready = 1.
  - frd, rd_out and fflags read 0 while empty.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Simultaneous push and pop:
  - Legal when full: in_ready depends only on the registered count, so a full buffer does not accept even if it pops the same cycle.
  - Legal when non-full: count unchanged.
  - Never bypass combinationally; an operation accepted in cycle N appears on out_valid in cycle N+1 at the earliest.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Head entry holds steady while out_valid && !out_ready (no change of frd, rd_out or fflags).
- Fix-up is computed combinationally on the input side and stored. Definitions:
  - NaN: exp = 0xFF, man != 0.
  - sNaN: NaN with man[22] = 0.
  - Inf: exp = 0xFF, man = 0.
  - sb = frs2[31] ^ Funct.
- Fix-up priority, first match wins:
  1. Any NaN operand -> frd = 0x7FC00000. NV = 1 if either operand is sNaN.
  2. Both Inf and frs1[31] != sb -> frd = 0x7FC00000, NV = 1.
  3. frs1 Inf -> frd = frs1.
  4. frs2 Inf -> frd = {sb, 0x7F800000[30:0]}.
  5. frd_raw exponent = 0xFF (overflow from finite operands) -> frd = {frd_raw[31], 0xFF, 23'b0}, OF = 1, NX = 1.
  6. Otherwise frd = frd_raw, flags = 0.
- DZ and UF are always 0. NX is only set on overflow, because the datapath truncates and reports no inexact.
- Reset mid-operation discards all buffered entries; no partial writeback.

Decomposition:
- Shared package fp_pkg holds:
  - Field positions (SIGN, EXPONENT, MANTISSA).
  - CANON_NAN = 32'h7FC00000 and POS_INF = 32'h7F800000.
  - fflags bit indices NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0.
  - FFLAGS_W = 5.
- One sub-module, fp_special_fixup: purely combinational. Inputs are frs1, frs2, Funct and frd_raw; outputs are the fixed frd and fflags. The buffer and handshake logic stay in fadd_result_stage.

Test Plan:
1. Normal add, out_ready = 1: frs1 = 0x3F800000, frs2 = 0x40000000, Funct = 0, frd_raw = 0x40400000, rd_in = 7 -> next cycle out_valid = 1, frd = 0x40400000, rd_out = 7, fflags = 0.
2. Inf minus Inf: frs1 = frs2 = 0x7F800000, Funct = 1 -> frd = 0x7FC00000, fflags = 5'b10000. With Funct = 0 -> frd = 0x7F800000, fflags = 0.
3. sNaN operand: frs1 = 0x7F800001, frs2 = 0x3F800000 -> frd = 0x7FC00000, NV = 1. Quiet NaN 0x7FC00001 -> same frd, fflags = 0.
4. Overflow: frs1 = frs2 = 0x7F7FFFFF, frd_raw = 0x7F8xxxxx -> frd = 0x7F800000, fflags = 5'b00101.
5. Backpressure: out_ready = 0, push 3 ops with rd 1, 2, 3 -> in_ready drops after 2 accepts and the third is held upstream. Raise out_ready -> outputs appear in order 1, 2, 3; no loss or duplicate; head is stable while stalled.
6. Assert RST with 2 entries buffered -> immediately out_valid = 0, in_ready = 1, fflags = 0. After release, the first new push emerges one cycle later.
